// File: rtl/mbox_rd_if.sv
// WISHBONE slave that drains the inbound byte mailbox and reassembles the bytes
// LSB-first into 32-bit words, double-buffered so the next word fills while the CPU reads.
module mbox_rd_if #(
  parameter int WB_AW  = 4,
  parameter int WB_DW  = 32,
  parameter int WOU_DW = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [WB_AW-1:2]  wb_adr_i,
  input  logic [WB_DW-1:0]  wb_dat_i,
  output logic [WB_DW-1:0]  wb_dat_o,
  output logic              wb_ack_o,
  output logic              mbox_rd_o,
  input  logic              mbox_empty_i,
  input  logic [WOU_DW-1:0] mbox_di_i
);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  localparam logic [WB_AW-1:2] ADR_IBUF = (WB_AW-2)'(0);
  localparam logic [WB_AW-1:2] ADR_STAT = (WB_AW-2)'(1);

  localparam logic [WB_AW-1:2] ADR_CTRL = (WB_AW-2)'(2);

  state_t           state_q;
  logic             mbox_rd_q;
  logic             asm_full_q;
  logic [1:0]       byte_cnt_q;
  logic [WB_DW-1:0] asm_buf_q;
  logic [WB_DW-1:0] hold_buf_q;
  logic             hold_valid_q, hold_valid_d;
  logic             ack_q, ack_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [15:0]      word_cnt_q;

  logic acc, ibuf_rd_sel, pop, flush, xfer;
  logic unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_dat_i[WB_DW-1:1]};

  assign acc         = wb_cyc_i & wb_stb_i;
  assign ibuf_rd_sel = acc & ~wb_we_i & (wb_adr_i == ADR_IBUF);
  // Pop needs the master still in the cycle, so an abandoned read never drops a word.
  assign pop         = ack_q & ibuf_rd_sel;
  assign flush       = ack_q & acc & wb_we_i & (wb_adr_i == ADR_CTRL) & wb_dat_i[0];
  assign xfer        = asm_full_q & (~hold_valid_q | pop) & ~flush;
  assign ack_d       = acc & ~ack_q & ~(ibuf_rd_sel & ~hold_valid_q);

  always_comb begin
    dat_d = dat_q;
    if (ack_d & ~wb_we_i) begin
      case (wb_adr_i)
        ADR_IBUF: dat_d = hold_buf_q;
        ADR_STAT: dat_d = {word_cnt_q, 12'd0, byte_cnt_q, mbox_empty_i, hold_valid_q};
        default:  dat_d = '0;
      endcase
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (flush)     hold_valid_d = 1'b0;
    else if (xfer) hold_valid_d = 1'b1;
    else if (pop)  hold_valid_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      hold_valid_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      hold_valid_q <= hold_valid_d;
      if (xfer) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (xfer) hold_buf_q <= asm_buf_q;
  end

  // Byte fetch: IDLE decides, RD pops, CAP captures the byte returned a cycle later.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      state_q    <= IDLE;
      mbox_rd_q  <= 1'b0;
      byte_cnt_q <= '0;
      asm_full_q <= 1'b0;
      asm_buf_q  <= '0;
    end else begin
      if (xfer) begin
        asm_full_q <= 1'b0;
        asm_buf_q  <= '0;
      end
      case (state_q)
        IDLE: begin
          if (~mbox_empty_i & ~asm_full_q) begin
            state_q   <= RD;
            mbox_rd_q <= 1'b1;
          end
        end
        RD: begin
          mbox_rd_q <= 1'b0;
          state_q   <= CAP;
        end
        CAP: begin
          asm_buf_q[{byte_cnt_q, 3'b000} +: WOU_DW] <= mbox_di_i;
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) asm_full_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mbox_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign mbox_rd_o = mbox_rd_q;

endmodule

// File: tb/tb_mbox_rd_if.sv
// Directed bench for mbox_rd_if: a byte-queue mailbox model plus a WISHBONE master
// driven from one linear initial block.
module tb_mbox_rd_if;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [3:2]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        mbox_rd_o;
  logic        mbox_empty_i;
  logic [7:0]  mbox_di_i;

  always #5 wb_clk_i = ~wb_clk_i;

  mbox_rd_if #(.WB_AW(4), .WB_DW(32), .WOU_DW(8)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .mbox_rd_o   (mbox_rd_o),
    .mbox_empty_i(mbox_empty_i),
    .mbox_di_i   (mbox_di_i)
  );

  logic [7:0] mq[$];
  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int rd_wide = 0;
  int ack_cnt = 0;
  logic rd_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, then run the mailbox model.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    if (mbox_rd_o) begin
      rd_pulses++;
      if (rd_prev) rd_wide++;
      if (mq.size() > 0) mbox_di_i = mq.pop_front();
    end
    rd_prev = mbox_rd_o;
    if (wb_ack_o) ack_cnt++;
    mbox_empty_i = (mq.size() == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] b);
    mq.push_back(b);
    mbox_empty_i = 1'b0;
  endtask

  task automatic wait_ack(input int bound, input string tag, output logic [31:0] d);
    int n;
    n = 0;
    d = '0;
    while (!wb_ack_o && n < bound) begin
      tick();
      n++;
    end
    if (!wb_ack_o) begin
      check({tag, "_ack_timeout"}, {31'd0, wb_ack_o}, 32'd1);
    end else begin
      d = wb_dat_o;
      tick();
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_rd(input logic [1:0] adr, input string tag, output logic [31:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    wait_ack(200, tag, d);
  endtask

  task automatic wb_wr(input logic [1:0] adr, input logic [31:0] wd, input string tag);
    logic [31:0] dummy;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = wd;
    wait_ack(20, tag, dummy);
  endtask

  initial begin
    logic [31:0] d;
    int snap, n;
    wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'hF; wb_adr_i = 2'd0; wb_dat_i = '0;
    mbox_empty_i = 1'b1; mbox_di_i = '0;
    ticks(3);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'h0);
    check("rst_rd", {31'd0, mbox_rd_o}, 32'h0);
    wb_rst_i = 1'b0;
    tick();
    wb_rd(2'd1, "stat0", d);
    check("stat0", d, 32'h0000_0002);

    // Single word, LSB-first
    rd_pulses = 0; rd_wide = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wb_rd(2'd0, "t1_ibuf", d);
    check("t1_ibuf", d, 32'h4433_2211);
    wb_rd(2'd1, "t1_stat", d);
    check("t1_stat", d, 32'h0001_0002);
    check("t1_rd_pulses", rd_pulses, 32'd4);
    check("t1_rd_wide", rd_wide, 32'd0);

    // Read stalls on empty mailbox until the word assembles
    snap = ack_cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
    ticks(20);
    check("t2_stall_ack", ack_cnt - snap, 32'd0);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    wait_ack(100, "t2_ibuf", d);
    ticks(5);
    check("t2_ibuf", d, 32'hDDCC_BBAA);
    check("t2_ack_count", ack_cnt - snap, 32'd1);

    // Double buffer and backpressure, from a fresh reset
    wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    ticks(40);
    wb_rd(2'd1, "t3_stat_full", d);
    check("t3_stat_full", d, 32'h0001_0003);
    snap = rd_pulses;
    push(8'h09);
    ticks(15);
    check("t3_backpressure", rd_pulses - snap, 32'd0);
    wb_rd(2'd0, "t3_ibuf0", d);
    check("t3_ibuf0", d, 32'h0403_0201);
    wb_rd(2'd0, "t3_ibuf1", d);
    check("t3_ibuf1", d, 32'h0807_0605);
    ticks(10);
    wb_rd(2'd1, "t3_stat", d);
    check("t3_stat", d, 32'h0002_0006);

    // Flush discards partial word, keeps word_cnt
    push(8'hE1); push(8'hE2);
    ticks(10);
    wb_rd(2'd1, "t4_stat_part", d);
    check("t4_stat_part", d, 32'h0002_000E);
    wb_wr(2'd2, 32'h1, "t4_flush");
    wb_rd(2'd1, "t4_stat_flush", d);
    check("t4_stat_flush", d, 32'h0002_0002);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    wb_rd(2'd0, "t4_ibuf", d);
    check("t4_ibuf", d, 32'h4030_2010);
    wb_rd(2'd2, "t4_ctrl", d);
    check("t4_ctrl_rd", d, 32'h0);
    wb_rd(2'd3, "t4_rsvd", d);
    check("t4_rsvd_rd", d, 32'h0);

    // Reset while a byte is being captured
    wb_rd(2'd1, "t5_stat_pre", d);
    check("t5_stat_pre", d, 32'h0003_0002);
    push(8'h55); push(8'h66);
    n = 0;
    while (!mbox_rd_o && n < 20) begin tick(); n++; end
    check("t5_rd_seen", {31'd0, mbox_rd_o}, 32'd1);
    tick();
    wb_rst_i = 1'b1;
    mq.delete();
    mbox_empty_i = 1'b1;
    tick();
    check("t5_rst_dat", wb_dat_o, 32'h0);
    check("t5_rst_ack", {31'd0, wb_ack_o}, 32'h0);
    check("t5_rst_rd", {31'd0, mbox_rd_o}, 32'h0);
    wb_rst_i = 1'b0;

    // Empty mailbox for 100 cycles
    snap = rd_pulses;
    ticks(100);
    check("t6_no_rd", rd_pulses - snap, 32'd0);
    wb_rd(2'd1, "t6_stat", d);
    check("t6_stat", d, 32'h0000_0002);
    push(8'h77);
    ticks(10);
    check("t6_rd_resume", rd_pulses - snap, 32'd1);

    // Abandoned IBUF read neither acks nor pops
    snap = ack_cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
    ticks(5);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ticks(3);
    check("t7_abandon_ack", ack_cnt - snap, 32'd0);
    push(8'h88); push(8'h99); push(8'hAA);
    ticks(20);
    wb_rd(2'd1, "t7_stat", d);
    check("t7_stat", d, 32'h0001_0003);
    wb_rd(2'd0, "t7_ibuf", d);
    check("t7_ibuf", d, 32'hAA99_8877);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbox_rd_if.md
Name: mbox_rd_if

Overview:
- WISHBONE slave that drains the inbound byte mailbox FIFO (WOU stream, clk_500 domain) and presents 32-bit words to the CPU.
- Reassembles bytes least-significant-byte first, the same order the outbound mailbox writer serialises them.
- A double buffer (assembly register plus hold register) lets the next word fill while the CPU reads the current one.
- Status, word counter and flush control are exposed as WISHBONE registers.

Parameters:
- WB_AW, 4: WISHBONE lower address width; wb_adr_i[WB_AW-1:2] decodes the registers.
- WB_DW, 32: WISHBONE data width; only 32 is supported.
- WOU_DW, 8: mailbox byte width; only 8 is supported.

Ports:
- wb_clk_i  in  1  clock (clk_500). One clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_cyc_i  in  1  WISHBONE cycle.
- wb_stb_i  in  1  WISHBONE strobe.
- wb_we_i  in  1  WISHBONE write enable.
- wb_sel_i  in  4  byte selects; ignored (32-bit access only).
- wb_adr_i  in  WB_AW-2  register address, wb_adr_i[WB_AW-1:2].
- wb_dat_i  in  WB_DW  write data.
- wb_dat_o  out  WB_DW  registered read data.
- wb_ack_o  out  1  registered acknowledge.
- mbox_rd_o  out  1  mailbox pop strobe.
- mbox_empty_i  in  1  mailbox empty flag.
- mbox_di_i  in  WOU_DW  mailbox read data, valid the cycle after mbox_rd_o.

Behaviour:
- Register map, wb_adr_i[3:2]:
  - 0 MBOX_IBUF (R): hold word; a read pops it.
  - 1 MBOX_STAT (R): {word_cnt[15:0], 12'd0, byte_cnt[1:0], mbox_empty_i, hold_valid}.
  - 2 MBOX_CTRL (W): bit0 = flush; reads return 0.
  - 3: reserved; reads return 0, writes are ignored.
- Reset values: wb_dat_o=0, wb_ack_o=0, mbox_rd_o=0, hold_valid=0, byte_cnt=0, word_cnt=0, asm_buf=0, FSM=IDLE.
- Acknowledge: wb_ack_o <= cyc & stb & ~wb_ack_o & ~(ibuf_rd_sel & ~hold_valid). A MBOX_IBUF read stalls until a word is held; all other accesses ack after 1 cycle.
- Pop: in the cycle wb_ack_o=1 for a MBOX_IBUF read, hold_valid clears. wb_dat_o was loaded with hold_buf in the same edge that raised ack.
- Byte fetch FSM:
  - IDLE: if ~mbox_empty_i & ~asm_full, go RD.
  - RD: mbox_rd_o=1 for exactly one cycle, then go CAP.
  - CAP: asm_buf[8*byte_cnt +: 8] <= mbox_di_i; byte_cnt++ (wraps 3->0); go IDLE. If byte_cnt was 3, set asm_full.
  - Sustained throughput is 1 byte per 3 cycles.
  - mbox_rd_o is never asserted while mbox_empty_i=1 at the decision point (IDLE).
- Transfer: when asm_full & (~hold_valid | pop this cycle), then hold_buf <= asm_buf, hold_valid=1, asm_full=0, word_cnt++ (16-bit wrap), asm_buf cleared.
  - Simultaneous pop and transfer leaves hold_valid=1 with the new word.
- Backpressure: while asm_full=1 the FSM stays in IDLE; no mailbox reads occur.
- Flush (write MBOX_CTRL bit0=1, applied on the ack cycle):
  - Clears asm_buf, asm_full, byte_cnt and hold_valid; FSM goes to IDLE.
  - A byte in flight (FSM in CAP) is discarded.
  - word_cnt is not cleared.
  - Flush has priority over a transfer in the same cycle.
- Reset mid-word: all partial state is lost; bytes already popped from the mailbox are not recovered.
- A stalled IBUF read that the master abandons (cyc drops) must not pop or ack.

Test Plan:
- Mailbox holds 0x11,0x22,0x33,0x44; read IBUF -> 0x44332211; STAT word_cnt=1, hold_valid=0 after the read; exactly 4 mbox_rd_o pulses, each 1 cycle wide.
- IBUF read issued with the mailbox empty; feed bytes 0xAA,0xBB,0xCC,0xDD 20 cycles later -> ack is held low until the word assembles, then data=0xDDCCBBAA with a single ack.
- Push 8 bytes 0x01..0x08 with no CPU reads -> hold=0x04030201, asm_full=1, mbox_rd_o stops; read -> 0x04030201; next read -> 0x08070605; word_cnt=2.
- Push 2 bytes, then write CTRL=1 -> STAT byte_cnt=0, hold_valid=0; push 0x10,0x20,0x30,0x40 -> read 0x40302010.
- Assert wb_rst_i while the FSM is in CAP -> all outputs return to reset values on the next edge; no further mbox_rd_o until ~mbox_empty_i.
- Drive mbox_empty_i=1 continuously for 100 cycles -> mbox_rd_o stays 0; STAT reads 0x00000002.
